// File: rtl/view_matrix_gen.sv
// Camera-position registers with saturating per-frame moves and a registered
// translate-only 4x4 view matrix, presented to the MVP stage on valid/ready.

module vmg_axis #(
  parameter int              W       = 16,
  parameter logic [W-1:0]    STEP    = 16'h0010,
  parameter logic [W-1:0]    POS_MAX = 16'h7F00,
  parameter logic [W-1:0]    POS_MIN = 16'h8100
) (
  input  logic [W-1:0] i_pos,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_ld,
  output logic [W-1:0] o_next
);
  localparam logic signed [W:0] MAX_EXT = {POS_MAX[W-1], POS_MAX};
  localparam logic signed [W:0] MIN_EXT = {POS_MIN[W-1], POS_MIN};

  logic signed [W:0] w_ext, w_step, w_src;

  assign w_ext  = {i_pos[W-1], i_pos};
  assign w_step = {STEP[W-1], STEP};

  // One guard bit keeps pos+/-STEP exact before clamping to the legal range.
  always_comb begin
    w_src = w_ext;
    if (i_load)     w_src = {i_ld[W-1], i_ld};
    else if (i_inc) w_src = w_ext + w_step;
    else if (i_dec) w_src = w_ext - w_step;
    o_next = w_src[W-1:0];
    if (w_src > MAX_EXT)      o_next = POS_MAX;
    else if (w_src < MIN_EXT) o_next = POS_MIN;
  end
endmodule

module view_matrix_gen #(
  parameter int                 WI      = 8,
  parameter int                 WF      = 8,
  parameter logic [WI+WF-1:0]   STEP    = 16'h0010,
  parameter logic [WI+WF-1:0]   X_INIT  = 16'h0000,
  parameter logic [WI+WF-1:0]   Y_INIT  = 16'h0000,
  parameter logic [WI+WF-1:0]   Z_INIT  = 16'h0500,
  parameter logic [WI+WF-1:0]   POS_MAX = 16'h7F00,
  parameter logic [WI+WF-1:0]   POS_MIN = 16'h8100
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic [5:0]                  move,
  input  logic                        load,
  input  logic [WI+WF-1:0]            load_x,
  input  logic [WI+WF-1:0]            load_y,
  input  logic [WI+WF-1:0]            load_z,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [15:0][WI+WF-1:0]      view_matrix,
  output logic [WI+WF-1:0]            x_pos,
  output logic [WI+WF-1:0]            y_pos,
  output logic [WI+WF-1:0]            z_pos,
  output logic                        busy,
  output logic [7:0]                  drop_cnt
);
  localparam int W = WI + WF;
  localparam logic [W-1:0]      ONE      = W'(1) << WF;
  localparam logic [W-1:0]      MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]      MOST_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [2:0][W-1:0] P_INIT   = {Z_INIT, Y_INIT, X_INIT};

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_BUILD, S_HOLD} state_t;

  state_t              r_state, w_next_state;
  logic [5:0]          r_move;
  logic                r_load;
  logic [2:0][W-1:0]   r_ld;
  logic [2:0][W-1:0]   r_pos;
  logic [2:0][W-1:0]   w_next_pos;
  logic [15:0][W-1:0]  r_view;
  logic [7:0]          r_drop;
  logic                w_accept;

  // Negating the most-negative code would wrap; pin it to the largest positive.
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return ~v + W'(1);
  endfunction

  function automatic logic [15:0][W-1:0] mk_view(input logic [2:0][W-1:0] p);
    logic [15:0][W-1:0] m;
    m     = '0;
    m[0]  = ONE;
    m[5]  = ONE;
    m[10] = ONE;
    m[15] = ONE;
    m[3]  = sat_neg(p[0]);
    m[7]  = sat_neg(p[1]);
    m[11] = sat_neg(p[2]);
    return m;
  endfunction

  assign w_accept = (r_state == S_IDLE) && frame_start;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (frame_start) w_next_state = S_MOVE;
      S_MOVE:  w_next_state = S_BUILD;
      S_BUILD: w_next_state = S_HOLD;
      S_HOLD:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_move <= '0;
      r_load <= 1'b0;
      r_ld   <= '0;
    end else if (w_accept) begin
      r_move <= move;
      r_load <= load;
      r_ld   <= {load_z, load_y, load_x};
    end
  end

  // move bit pairs per axis: [2a] = +axis, [2a+1] = -axis
  for (genvar a = 0; a < 3; a++) begin : g_axis
    vmg_axis #(
      .W(W), .STEP(STEP), .POS_MAX(POS_MAX), .POS_MIN(POS_MIN)
    ) u_axis (
      .i_pos  (r_pos[a]),
      .i_inc  (r_move[2*a] & ~r_move[2*a+1]),
      .i_dec  (r_move[2*a+1] & ~r_move[2*a]),
      .i_load (r_load),
      .i_ld   (r_ld[a]),
      .o_next (w_next_pos[a])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset)                   r_pos <= P_INIT;
    else if (r_state == S_MOVE)  r_pos <= w_next_pos;
  end

  always_ff @(posedge Clk) begin
    if (Reset)                   r_view <= mk_view(P_INIT);
    else if (r_state == S_BUILD) r_view <= mk_view(r_pos);
  end

  // Requests arriving mid-frame are dropped, not queued; count them for debug.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_drop <= '0;
    else if (frame_start && (r_state != S_IDLE) && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign out_valid   = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign view_matrix = r_view;
  assign x_pos       = r_pos[0];
  assign y_pos       = r_pos[1];
  assign z_pos       = r_pos[2];
  assign drop_cnt    = r_drop;
endmodule

// File: tb/tb_view_matrix_gen.sv
// Bench for view_matrix_gen: table of frame commands checked through a scoreboard,
// plus hand sequences for backpressure, drop counting and reset during HOLD.

module tb_view_matrix_gen;
  logic              Clk, Reset, frame_start, load, out_ready, out_valid, busy;
  logic [5:0]        move;
  logic [15:0]       load_x, load_y, load_z, x_pos, y_pos, z_pos;
  logic [15:0][15:0] view_matrix;
  logic [7:0]        drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  mv;
    logic        ld;
    logic [15:0] lx, ly, lz;
    logic [15:0] ex, ey, ez, n3, n7, n11;
  } vec_t;

  typedef struct {
    logic [15:0]       x, y, z;
    logic [15:0][15:0] m;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  view_matrix_gen dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .move(move), .load(load),
    .load_x(load_x), .load_y(load_y), .load_z(load_z), .out_ready(out_ready),
    .out_valid(out_valid), .view_matrix(view_matrix), .x_pos(x_pos), .y_pos(y_pos),
    .z_pos(z_pos), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0][15:0] mk(input logic [15:0] a, b, c);
    logic [15:0][15:0] m;
    m = '0;
    m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
    m[3] = a; m[7] = b; m[11] = c;
    return m;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("x_pos", x_pos, e.x);
        chk("y_pos", y_pos, e.y);
        chk("z_pos", z_pos, e.z);
        chk("matrix", view_matrix, e.m);
      end
    end
  end

  task automatic run_frame(input vec_t v, input int idx);
    exp_t e;
    int   n;
    e.x = v.ex; e.y = v.ey; e.z = v.ez; e.m = mk(v.n3, v.n7, v.n11);
    move = v.mv; load = v.ld; load_x = v.lx; load_y = v.ly; load_z = v.lz;
    frame_start = 1'b1;
    sb.push_back(e);
    tick();
    frame_start = 1'b0; move = '0; load = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("latency[%0d]", idx), n, 3);
    tick();
    chk($sformatf("valid_one_cycle[%0d]", idx), out_valid, 0);
  endtask

  initial begin
    exp_t e;
    Reset = 1'b1; frame_start = 1'b0; move = '0; load = 1'b0;
    load_x = '0; load_y = '0; load_z = '0; out_ready = 1'b1;
    tick(); tick();
    Reset = 1'b0;

    // reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst_x",     x_pos, 16'h0000);
    chk("rst_y",     y_pos, 16'h0000);
    chk("rst_z",     z_pos, 16'h0500);
    chk("rst_matrix", view_matrix, mk(16'h0000, 16'h0000, 16'hFB00));

    //           move        ld   lx        ly        lz        ex        ey        ez        n3        n7        n11
    vecs[0]  = '{6'b000001, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0500, 16'hFFF0, 16'h0000, 16'hFB00};
    vecs[1]  = '{6'b000011, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0500, 16'hFFF0, 16'h0000, 16'hFB00};
    vecs[2]  = '{6'b000010, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0500, 16'h0000, 16'h0000, 16'hFB00};
    vecs[3]  = '{6'b000000, 1, 16'h7FF8, 16'h0000, 16'h0500, 16'h7F00, 16'h0000, 16'h0500, 16'h8100, 16'h0000, 16'hFB00};
    vecs[4]  = '{6'b000001, 0, 16'h0000, 16'h0000, 16'h0000, 16'h7F00, 16'h0000, 16'h0500, 16'h8100, 16'h0000, 16'hFB00};
    vecs[5]  = '{6'b000100, 1, 16'h7F00, 16'h0200, 16'h0500, 16'h7F00, 16'h0200, 16'h0500, 16'h8100, 16'hFE00, 16'hFB00};
    vecs[6]  = '{6'b000000, 1, 16'h8000, 16'hFE00, 16'h0000, 16'h8100, 16'hFE00, 16'h0000, 16'h7F00, 16'h0200, 16'h0000};
    vecs[7]  = '{6'b000010, 0, 16'h0000, 16'h0000, 16'h0000, 16'h8100, 16'hFE00, 16'h0000, 16'h7F00, 16'h0200, 16'h0000};
    vecs[8]  = '{6'b011000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h8100, 16'hFDF0, 16'h0010, 16'h7F00, 16'h0210, 16'hFFF0};
    vecs[9]  = '{6'b110000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h8100, 16'hFDF0, 16'h0010, 16'h7F00, 16'h0210, 16'hFFF0};
    vecs[10] = '{6'b000000, 1, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7F00, 16'h0000, 16'h0000, 16'h8100};

    for (int i = 0; i < 11; i++) run_frame(vecs[i], i);
    chk("drop_after_table", drop_cnt, 0);

    // backpressure with dropped requests
    out_ready = 1'b0;
    e.x = 16'h0010; e.y = 16'h0000; e.z = 16'h7F00; e.m = mk(16'hFFF0, 16'h0000, 16'h8100);
    move = 6'b000001; frame_start = 1'b1;
    sb.push_back(e);
    tick();
    move = '0;
    tick();
    frame_start = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid[%0d]", k), out_valid, 1);
      chk($sformatf("bp_matrix[%0d]", k), view_matrix, e.m);
      frame_start = (k == 1 || k == 3);
      tick();
      frame_start = 1'b0;
    end
    chk("bp_drop3", drop_cnt, 3);
    chk("bp_busy",  busy, 1);
    chk("bp_x",     x_pos, 16'h0010);
    out_ready = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("accept_valid_low", out_valid, 0);
    chk("same_cycle_drop", drop_cnt, 4);
    tick();
    chk("same_cycle_not_accepted", busy, 0);
    chk("sb_drained", sb.size(), 0);

    // drop counter saturation, then reset while holding
    out_ready = 1'b0;
    e.x = 16'h0010; e.y = 16'h0010; e.z = 16'h7F00; e.m = mk(16'hFFF0, 16'hFFF0, 16'h8100);
    move = 6'b000100; frame_start = 1'b1;
    sb.push_back(e);
    tick();
    move = '0;
    for (int k = 0; k < 260; k++) tick();
    frame_start = 1'b0;
    chk("drop_sat", drop_cnt, 8'hFF);
    chk("hold_valid", out_valid, 1);
    chk("hold_y", y_pos, 16'h0010);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    sb.delete();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_busy",  busy, 0);
    chk("rst2_drop",  drop_cnt, 0);
    chk("rst2_x",     x_pos, 16'h0000);
    chk("rst2_y",     y_pos, 16'h0000);
    chk("rst2_z",     z_pos, 16'h0500);
    chk("rst2_matrix", view_matrix, mk(16'h0000, 16'h0000, 16'hFB00));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("rst2_no_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
